// File: rtl/inv_mixcolumns_seq.sv
// AES InvMixColumns, sequential: COLS_PER_CYCLE columns per BUSY cycle.
// One state in flight; valid/ready handshake on both sides.
module inv_mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] inputState,
  input  logic         inValid,
  output logic         inReady,
  output logic [127:0] outputState,
  output logic         outValid,
  input  logic         outReady
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] STEP  = 3'(COLS_PER_CYCLE);
  localparam logic [1:0] STEP2 = 2'(COLS_PER_CYCLE);

  state_t       state;
  logic [1:0]   colCnt;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic         last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 9/b/d/e products share one x2-x4-x8 chain per byte
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2    = xt(s[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    work_nxt = work;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= {1'b0, colCnt} &&
          3'(i) < {1'b0, colCnt} + STEP) begin
        work_nxt[127-32*i -: 32] =
          inv_col(work[127-32*i -: 32]);
      end
    end
  end

  assign last = ({1'b0, colCnt} + STEP) == 3'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      colCnt      <= '0;
      work        <= '0;
      outputState <= '0;
      outValid    <= 1'b0;
      inReady     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (inValid && inReady) begin
            work    <= inputState;
            colCnt  <= '0;
            inReady <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          work   <= work_nxt;
          colCnt <= colCnt + STEP2;
          if (last) begin
            outputState <= work_nxt;
            outValid    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          outValid <= 1'b0;
          inReady  <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// Bench for inv_mixcolumns_seq at 1, 2 and 4 columns per cycle.
// Reference is a GF(2^8) matrix product over the state.
module tb_inv_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din  [3];
  logic [127:0] dout [3];
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t      [3];
  logic [127:0] b2b [3];

  localparam logic [31:0] FWD = 32'h02030101;
  localparam logic [31:0] INV = 32'h0e0b0d09;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_mixcolumns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inputState(din[0]), .inValid(iv[0]), .inReady(ir[0]),
    .outputState(dout[0]), .outValid(ov[0]), .outReady(ordy[0])
  );
  inv_mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .inputState(din[1]), .inValid(iv[1]), .inReady(ir[1]),
    .outputState(dout[1]), .outValid(ov[1]), .outReady(ordy[1])
  );
  inv_mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .inputState(din[2]), .inValid(iv[2]), .inReady(ir[2]),
    .outputState(dout[2]), .outValid(ov[2]), .outReady(ordy[2])
  );

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // circulant matrix: row r, col j uses m[(j - r) mod 4]
  function automatic logic [127:0] mixc(input logic [127:0] s,
                                        input logic [31:0] m);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(m[31-8*((j-r)&3) -: 8],
                      s[127-32*c-8*j -: 8]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input int k, input logic [127:0] d);
    check("in_ready", 128'(ir[k]), 128'd1);
    din[k] = d;
    iv[k]  = 1'b1;
    tick();
    iv[k]  = 1'b0;
  endtask

  task automatic xact(input int k, input logic [127:0] d,
                      input logic [127:0] exp, input string tag);
    int n;
    send(k, d);
    wait_ov(k, n);
    check({tag, "_lat"}, 128'(n), 128'(4 >> k));
    check(tag, dout[k], exp);
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    check({tag, "_rdy"}, 128'(ir[k]), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [127:0] s;
    logic [127:0] e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k]  = '0;
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_rdy", 128'(ir[k]), 128'd1);
      check("rst_ov", 128'(ov[k]), 128'd0);
      check("rst_out", dout[k], 128'd0);
    end

    for (int k = 0; k < 3; k++) begin
      xact(k, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
           128'hdb135345_f20a225c_01010101_d4d4d4d5, "vec1");
      xact(k, {4{32'h4d7ebdf8}}, {4{32'h2d26314c}}, "vec2");
    end

    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      xact(i % 3, mixc(s, FWD), s, "round_trip");
    end

    // stall in DONE while new inputs toggle
    s = rnd128();
    e = mixc(s, INV);
    send(0, s);
    wait_ov(0, n);
    check("bp_lat", 128'(n), 128'd4);
    for (int i = 0; i < 10; i++) begin
      iv[0]  = ~iv[0];
      din[0] = rnd128();
      tick();
      check("bp_ov", 128'(ov[0]), 128'd1);
      check("bp_out", dout[0], e);
      check("bp_rdy", 128'(ir[0]), 128'd0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    check("bp_rel_rdy", 128'(ir[0]), 128'd1);
    check("bp_rel_ov", 128'(ov[0]), 128'd0);
    check("bp_hold", dout[0], e);

    // reset in the second BUSY cycle
    send(0, rnd128());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ov", 128'(ov[0]), 128'd0);
    check("mid_rst_out", dout[0], 128'd0);
    check("mid_rst_rdy", 128'(ir[0]), 128'd1);
    s = rnd128();
    xact(0, mixc(s, FWD), s, "post_rst");

    // back-to-back with inValid held high
    for (int j = 0; j < 3; j++) b2b[j] = rnd128();
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          int  g;
          bit  acc;
          g   = 0;
          acc = 1'b0;
          din[0] = mixc(b2b[j], FWD);
          iv[0]  = 1'b1;
          while (!acc && g < 40) begin
            acc = ir[0];
            tick();
            g++;
          end
        end
        iv[0] = 1'b0;
      end
      begin
        ordy[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
          int m;
          wait_ov(0, m);
          check("b2b_valid", 128'(ov[0]), 128'd1);
          t[j] = cyc;
          check("b2b_out", dout[0], b2b[j]);
          tick();
        end
        ordy[0] = 1'b0;
      end
    join
    check("b2b_gap1", 128'(t[1] - t[0]), 128'd6);
    check("b2b_gap2", 128'(t[2] - t[1]), 128'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mixcolumns_seq.md
Name: inv_mixcolumns_seq

Overview:
- Sequential AES InvMixColumns stage for the decryption datapath; inverse of the encrypt-side MixColumns.
- Takes a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Returns the transformed state over a valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is a elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inputState  input  128  state to transform. Column c occupies bits [127-32c : 96-32c]; row 0 is the MSB byte of each column.
- inValid  input  1  inputState is valid.
- inReady  output  1  block can accept a state.
- outputState  output  128  transformed state, same byte layout as inputState.
- outValid  output  1  outputState is valid.
- outReady  input  1  downstream accepts outputState.

Behaviour:
- Arithmetic: GF(2^8) with reduction polynomial 0x11B. For each column s0..s3:
  - o0 = 0e*s0 ^ 0b*s1 ^ 0d*s2 ^ 09*s3
  - o1 = 09*s0 ^ 0e*s1 ^ 0b*s2 ^ 0d*s3
  - o2 = 0d*s0 ^ 09*s1 ^ 0e*s2 ^ 0b*s3
  - o3 = 0b*s0 ^ 0d*s1 ^ 09*s2 ^ 0e*s3
  - Products are built from xtime chains (x2, x4, x8 plus XOR). There is no generic multiplier loop.
- State machine: IDLE, BUSY, DONE.
  - IDLE: inReady=1. On inValid&&inReady, latch inputState into the working register, set colCnt=0, go to BUSY.
  - BUSY: each cycle transform columns colCnt .. colCnt+COLS_PER_CYCLE-1 in the working register, then add COLS_PER_CYCLE to colCnt. When the final group completes, copy the working register to outputState and go to DONE.
  - DONE: outValid=1. On outReady go to IDLE; otherwise stay in DONE.
- Latency: acceptance edge to outValid high is 4/COLS_PER_CYCLE cycles (4, 2 or 1).
- Throughput: one state per 4/COLS_PER_CYCLE+2 cycles. There is no overlap between states.
- inReady is high only in IDLE. inValid in any other state is ignored and does not corrupt in-flight data.
- outValid is low outside DONE.
- outputState changes only on the edge entering DONE. It holds its value at all other times, including while stalled with outValid=1 and outReady=0, and after the handshake.
- colCnt is 2 bits. It wraps to 0 on entry to DONE and is reset on every acceptance.
- Reset (rst=1 at an edge): state=IDLE, colCnt=0, working register=0, outputState=0, outValid=0.
  - inReady is 1 in the first cycle after reset release.
  - Reset in BUSY or DONE discards the in-flight state with no output.
  - Reset has priority over every handshake in the same cycle.
- outReady asserted while not in DONE has no effect.

Test Plan:
1. Single column vector, COLS_PER_CYCLE=1: inputState=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> outputState=db135345_f20a225c_01010101_d4d4d4d5, with outValid exactly 4 cycles after acceptance.
2. Latency sweep: repeat scenario 1 with COLS_PER_CYCLE=2 and with 4 -> same outputState, with outValid at 2 cycles and 1 cycle respectively.
3. Round-trip against the encrypt-side MixColumns: 1000 random 128-bit states pass through MixColumns, then this block -> output equals the original state in every case. Also check inputState=4d7ebdf8 repeated four times -> 2d26314c repeated four times.
4. Backpressure: hold outReady=0 for 10 cycles after outValid -> outValid and outputState stay stable and inReady=0. Toggle inValid with new data during the stall -> no effect. Release outReady -> IDLE next cycle and inReady=1.
5. Reset mid-operation: assert rst in the 2nd BUSY cycle -> next cycle outValid=0, outputState=0, inReady=1. A new state is accepted afterwards and produces the correct result.
6. Back-to-back traffic: inValid held high with 3 queued states and outReady=1 -> 3 correct results in order, spaced 6 cycles apart for COLS_PER_CYCLE=1.
